// File: rtl/hazard_forward_unit.sv
// -----------------------------------------------------------------------------
// hazard_forward_unit
//
// Operand forwarding and hazard control that sits beside the ID/EX register.
//   - Resolves NRP operand read ports from the EX/MEM and MEM/WB stages.
//   - Raises load-use (stall + bubble) and memory-wait (stall + hold) controls.
//   - Buffers load data that returns while the whole pipeline is externally
//     frozen, so the data is not lost when MEM/WB cannot advance.
//   - Keeps a saturating stall-cycle counter and a sticky memory-timeout flag.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   idex_re / idex_raddr       per-port read enable / source register
//   rf_val                     per-port register-file value
//   exmem_*                    EX/MEM write enable, dest, source, candidates
//   memwb_*                    MEM/WB write enable, dest, source, candidates
//   mem_rdata(_valid)          load data and its valid strobe
//   ext_stall                  external freeze of the whole pipeline
//   cnt_clr                    synchronous clear of stall_cnt
//   fwd_val                    resolved operands (combinational)
//   stall / flush_ex / mem_hold  pipeline controls (combinational)
//   state                      registered FSM state: 0 RUN, 1 LU, 2 MWAIT
//   mem_timeout                sticky memory-timeout flag
//   stall_cnt                  saturating count of stall cycles
// -----------------------------------------------------------------------------
module hazard_forward_unit #(
  parameter int W       = 32,
  parameter int RA      = 5,
  parameter int NRP     = 2,
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NRP-1:0]     idex_re,
  input  logic [NRP*RA-1:0]  idex_raddr,
  input  logic [NRP*W-1:0]   rf_val,
  input  logic               exmem_reg_write,
  input  logic [RA-1:0]      exmem_waddr,
  input  logic [1:0]         exmem_wsrc,
  input  logic [W-1:0]       exmem_alu,
  input  logic [W-1:0]       exmem_pc,
  input  logic [W-1:0]       exmem_imm,
  input  logic               memwb_reg_write,
  input  logic [RA-1:0]      memwb_waddr,
  input  logic [1:0]         memwb_wsrc,
  input  logic [W-1:0]       memwb_alu,
  input  logic [W-1:0]       memwb_pc,
  input  logic [W-1:0]       memwb_imm,
  input  logic [W-1:0]       mem_rdata,
  input  logic               mem_rdata_valid,
  input  logic               ext_stall,
  input  logic               cnt_clr,
  output logic [NRP*W-1:0]   fwd_val,
  output logic               stall,
  output logic               flush_ex,
  output logic               mem_hold,
  output logic [1:0]         state,
  output logic               mem_timeout,
  output logic [CNT_W-1:0]   stall_cnt
);

  localparam logic [1:0] SRC_ALU = 2'd0;
  localparam logic [1:0] SRC_MEM = 2'd1;
  localparam logic [1:0] SRC_PC4 = 2'd2;
  localparam logic [1:0] SRC_IMM = 2'd3;

  // Wait counter only needs to reach TIMEOUT, where it saturates.
  localparam int              WC_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WC_W-1:0] WC_MAX = WC_W'(TIMEOUT);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_LU    = 2'd1,
    ST_MWAIT = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             ld_buf_valid;
  logic [W-1:0]     ld_buf_data;
  logic [WC_W-1:0]  wcnt_q, wcnt_d;

  logic             ld_ready;
  logic [W-1:0]     ld_data;
  logic [W-1:0]     exmem_val, memwb_val;
  logic [NRP-1:0]   ex_hit, wb_hit;
  logic             memwb_is_load;
  logic             lu, mem_wait;

  // Value a stage will write back, selected by its write-source field.
  function automatic logic [W-1:0] stage_val(
    input logic [1:0]   src,
    input logic [W-1:0] alu,
    input logic [W-1:0] pc,
    input logic [W-1:0] imm,
    input logic [W-1:0] ld
  );
    logic [W-1:0] v;
    unique case (src)
      SRC_ALU: v = alu;
      SRC_MEM: v = ld;
      SRC_PC4: v = pc + W'(4);
      SRC_IMM: v = imm;
      default: v = alu;
    endcase
    return v;
  endfunction

  // A buffered load counts as returned data until MEM/WB advances.
  assign ld_ready      = mem_rdata_valid | ld_buf_valid;
  assign ld_data       = mem_rdata_valid ? mem_rdata : ld_buf_data;
  assign memwb_is_load = memwb_reg_write && (memwb_wsrc == SRC_MEM);

  // EX/MEM loads have no data yet; that case is caught as a load-use hazard.
  assign exmem_val = stage_val(exmem_wsrc, exmem_alu, exmem_pc, exmem_imm, ld_data);
  assign memwb_val = stage_val(memwb_wsrc, memwb_alu, memwb_pc, memwb_imm, ld_data);

  for (genvar g = 0; g < NRP; g++) begin : g_port
    logic [RA-1:0] ra;
    assign ra = idex_raddr[g*RA +: RA];

    assign ex_hit[g] = idex_re[g] && exmem_reg_write &&
                       (exmem_waddr != '0) && (exmem_waddr == ra);
    assign wb_hit[g] = idex_re[g] && memwb_reg_write &&
                       (memwb_waddr != '0) && (memwb_waddr == ra);

    assign fwd_val[g*W +: W] =
      (ex_hit[g] && (exmem_wsrc != SRC_MEM))              ? exmem_val :
      (wb_hit[g] && ((memwb_wsrc != SRC_MEM) || ld_ready)) ? memwb_val :
                                                             rf_val[g*W +: W];
  end

  assign lu       = (|ex_hit) && (exmem_wsrc == SRC_MEM);
  assign mem_wait = memwb_is_load && !ld_ready;

  // Control outputs: a memory wait dominates a load-use hazard.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path through
    // the block leaves it unassigned and no latch is inferred.
    stall    = 1'b0;
    flush_ex = 1'b0;
    mem_hold = 1'b0;
    if (mem_wait) begin
      stall    = 1'b1;
      mem_hold = 1'b1;
    end else if (lu) begin
      stall    = 1'b1;
      flush_ex = 1'b1;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = ST_RUN;
    if (mem_wait)  state_d = ST_MWAIT;
    else if (lu)   state_d = ST_LU;
  end

  // State register.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_RUN;
    else        state_q <= state_d;
  end

  assign state = state_q;

  // Load buffer: catches data that returns while the pipeline is frozen and
  // releases it the first cycle MEM/WB advances.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the data word is reset too, so a stale load can never leak into
      // ld_data after reset even though ld_buf_valid already gates it.
      ld_buf_valid <= 1'b0;
      ld_buf_data  <= '0;
    end else if (mem_rdata_valid && memwb_is_load && ext_stall) begin
      ld_buf_valid <= 1'b1;
      ld_buf_data  <= mem_rdata;
    end else if (!ext_stall && !mem_hold) begin
      ld_buf_valid <= 1'b0;
    end
  end

  // Consecutive memory-wait cycles, saturating at TIMEOUT.
  always_comb begin
    wcnt_d = '0;
    if (mem_wait) wcnt_d = (wcnt_q == WC_MAX) ? wcnt_q : wcnt_q + WC_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt_q      <= '0;
      mem_timeout <= 1'b0;
    end else begin
      wcnt_q <= wcnt_d;
      // Flag rises on the edge that closes the TIMEOUT-th wait cycle.
      if ((TIMEOUT != 0) && mem_wait && (wcnt_d == WC_MAX)) mem_timeout <= 1'b1;
    end
  end

  // Stall-cycle counter; external freezes are not counted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          stall_cnt <= '0;
    else if (cnt_clr)                    stall_cnt <= '0;
    else if (stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
  end

endmodule

// File: doc/hazard_forward_unit.md
# hazard_forward_unit

- Parametrised successor to the EX-stage forwarding logic.
- Sits beside ID/EX and:
  - resolves operands for `NRP` read ports from the EX/MEM and MEM/WB stages;
  - generates load-use and variable-latency memory stall/flush controls;
  - buffers load data that arrives while the pipeline is externally held;
  - keeps a saturating stall-cycle counter and a sticky memory-timeout flag.

## Interface
Parameters:
- `W`, 32, data word width
- `RA`, 5, register address width
- `NRP`, 2, number of operand read ports
- `TIMEOUT`, 255, max consecutive memory-wait cycles before flag; 0 disables
- `CNT_W`, 32, stall counter width

Ports:
- `clk`  in  1  clock; all state on rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `idex_re`  in  NRP  per-port read enable
- `idex_raddr`  in  NRP*RA  per-port source register (port i at bits [i*RA +: RA])
- `rf_val`  in  NRP*W  per-port register-file value
- `exmem_reg_write`  in  1  EX/MEM write enable
- `exmem_waddr`  in  RA  EX/MEM destination
- `exmem_wsrc`  in  2  EX/MEM write source: 0 ALU, 1 MEM, 2 PC+4, 3 IMM
- `exmem_alu`, `exmem_pc`, `exmem_imm`  in  W each  EX/MEM candidate values
- `memwb_reg_write`, `memwb_waddr`, `memwb_wsrc`  in  1/RA/2  MEM/WB write fields
- `memwb_alu`, `memwb_pc`, `memwb_imm`  in  W each  MEM/WB candidate values
- `mem_rdata`  in  W  load data
- `mem_rdata_valid`  in  1  load data valid this cycle
- `ext_stall`  in  1  external freeze of the whole pipeline
- `cnt_clr`  in  1  synchronous clear of `stall_cnt`
- `fwd_val`  out  NRP*W  resolved operands
- `stall`  out  1  hold PC, IF/ID, ID/EX
- `flush_ex`  out  1  insert bubble into EX/MEM
- `mem_hold`  out  1  hold EX/MEM and MEM/WB
- `state`  out  2  FSM state: 0 RUN, 1 LU, 2 MWAIT
- `mem_timeout`  out  1  sticky timeout flag
- `stall_cnt`  out  CNT_W  stall-cycle counter

## Operation
- Match rule for a stage: `reg_write && waddr != 0 && waddr == idex_raddr[i] && idex_re[i]`.
- Load readiness:
  - `ld_ready = mem_rdata_valid | ld_buf_valid`.
  - `ld_data = mem_rdata_valid ? mem_rdata : ld_buf_data`.
- Stage write values: ALU → alu; MEM → load data; PC+4 → pc+4 (mod 2^W); IMM → imm.
- Per-port priority:
  1. EX/MEM match with wsrc != MEM;
  2. MEM/WB match, provided that when its wsrc = MEM, `ld_ready` is 1;
  3. otherwise `rf_val[i]`.
  - A port with `idex_re=0` always outputs `rf_val[i]`.
- Hazards:
  - `lu`: any port matches EX/MEM with wsrc = MEM.
  - `mem_wait`: `memwb_reg_write && memwb_wsrc==MEM && !ld_ready`, independent of any port match.
- Controls (combinational):
  - `mem_wait` → `stall=1`, `mem_hold=1`, `flush_ex=0`. `mem_wait` has priority over `lu`.
  - else `lu` → `stall=1`, `flush_ex=1`, `mem_hold=0`.
  - else all three are 0.
- Load buffer:
  - Capture `mem_rdata` and set `ld_buf_valid` when `mem_rdata_valid` is 1, MEM/WB holds a load, and `ext_stall` is 1.
  - Clear `ld_buf_valid` on any cycle with `!ext_stall && !mem_hold`, i.e. when MEM/WB advances.
- FSM `next` each cycle: `mem_wait` ? MWAIT : `lu` ? LU : RUN. `state` shows the registered value.
- Wait counter:
  - Increments each cycle `mem_wait` is 1; reset to 0 when `mem_wait` is 0.
  - When `TIMEOUT != 0` and the counter reaches `TIMEOUT`, set `mem_timeout`. It stays set until reset.
  - The counter saturates at `TIMEOUT`.
- `stall_cnt`:
  - +1 each cycle `stall` is 1, saturating at all-ones.
  - `cnt_clr` has priority and zeroes it.
  - `ext_stall` alone does not count.

## Timing
- `fwd_val`, `stall`, `flush_ex` and `mem_hold` are combinational, with zero-cycle latency from their inputs.
- `state`, `ld_buf`, the wait counter, `mem_timeout` and `stall_cnt` update on the rising edge.
- Reset (asynchronous, `rst_n=0`): `state=RUN`, `ld_buf_valid=0`, `ld_buf_data=0`, wait counter 0, `mem_timeout=0`, `stall_cnt=0`.
  - Combinational outputs then follow the inputs with an empty buffer.
  - Reset asserted mid-MWAIT discards buffered data immediately.
- A load-use hazard costs exactly 1 stall cycle when memory returns data in the cycle the load reaches MEM/WB. Each further cycle without data adds 1 MWAIT cycle.
- `mem_rdata_valid` and `ext_stall` in the same cycle: data is captured and used as `ld_data` from the next cycle onward. No `mem_wait` is raised.

## Test plan
- Back-to-back ALU forwarding:
  - Stimulus: EX/MEM writes r3=0x11 (ALU), MEM/WB writes r3=0x22 (ALU), port0 reads r3.
  - Response: `fwd_val[0]=0x11`, no stall.
  - Remove the EX/MEM match → `0x22`.
  - Reading r0 → `rf_val`.
- Load-use:
  - Stimulus: EX/MEM load to r5, port1 reads r5.
  - Response: `stall=1`, `flush_ex=1`, `stall_cnt` 0→1.
  - Next cycle, with the load in MEM/WB and `mem_rdata_valid=1`, `mem_rdata=0xABCD`: `fwd_val[1]=0xABCD`, `state=LU`, stall 0.
- Memory wait plus timeout (`TIMEOUT=3`):
  - Stimulus: MEM/WB load with valid held low for 4 cycles.
  - Response: `stall=mem_hold=1` throughout; `state=MWAIT`; `mem_timeout` rises after the 3rd wait cycle and stays 1 after the load completes.
- External-stall capture:
  - Stimulus: `ext_stall=1` while `mem_rdata_valid` pulses with 0x5A5A; next cycle valid is 0.
  - Response: `ld_ready` holds, `fwd_val=0x5A5A`, `mem_hold=0`. The buffer clears on the first cycle with `ext_stall=0`.
- PC+4/IMM and counter:
  - Stimulus: EX/MEM PC+4 source with pc=0xFFFFFFFC.
  - Response: forwarded value 0x00000000.
  - With `CNT_W=2`: 5 stall cycles → `stall_cnt=3`. `cnt_clr` together with a stall → 0.
- Async reset mid-MWAIT:
  - Stimulus: drop `rst_n` between edges.
  - Response: `state=0` and `ld_buf_valid=0` immediately; `stall_cnt=0`.
